// File: rtl/alu_sequencer.sv
// Accumulator command sequencer for an external ALU: presents operands for SETTLE
// cycles, captures Y/Cout/Overflow into the accumulator and returns the result.
module alu_sequencer #(
  parameter int N      = 16,
  parameter int M      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_load,
  input  logic [M-1:0] cmd_op,
  input  logic         cmd_cin,
  input  logic [N-1:0] cmd_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_cin,
  output logic [M-1:0] alu_mode,
  input  logic [N-1:0] alu_y,
  input  logic         alu_cout,
  input  logic         alu_overflow,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_cout,
  output logic         res_ovf,
  output logic         ovf_sticky,
  output logic         busy
);

  localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          cmd_fire;
  logic          capture;
  logic          arith;

  assign alu_a    = acc;
  assign cmd_fire = (state == IDLE) && cmd_valid;
  assign capture  = (state == EXEC) && (cnt == CNT_LAST);
  // Cout/Overflow are only meaningful in the add/subtract modes.
  assign arith    = (alu_mode == M'(4)) || (alu_mode == M'(5));

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nx = cmd_load ? RESP : EXEC;
      end
      EXEC: begin
        if (cnt == CNT_LAST) state_nx = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      alu_b      <= '0;
      alu_mode   <= '0;
      alu_cin    <= 1'b0;
      cnt        <= '0;
      res_data   <= '0;
      res_cout   <= 1'b0;
      res_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (cmd_fire) begin
        if (cmd_load) begin
          acc        <= cmd_data;
          res_data   <= cmd_data;
          res_cout   <= 1'b0;
          res_ovf    <= 1'b0;
          ovf_sticky <= 1'b0;
        end else begin
          alu_b    <= cmd_data;
          alu_mode <= cmd_op;
          alu_cin  <= cmd_cin;
          cnt      <= '0;
        end
      end
      if (state == EXEC) cnt <= cnt + CW'(1);
      if (capture) begin
        acc        <= alu_y;
        res_data   <= alu_y;
        res_cout   <= arith & alu_cout;
        res_ovf    <= arith & alu_overflow;
        ovf_sticky <= ovf_sticky | (arith & alu_overflow);
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (SETTLE=1 and SETTLE=3) driven by directed
// vectors, a behavioural ALU, and a transaction-level model checked every cycle.
module tb_alu_sequencer;
  localparam int N = 16;
  localparam int M = 4;

  typedef struct packed {
    logic [N-1:0] y;
    logic         cout;
    logic         ovf;
  } alu_res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst        [2];
  logic         cmd_valid  [2];
  logic         cmd_ready  [2];
  logic         cmd_load   [2];
  logic [M-1:0] cmd_op     [2];
  logic         cmd_cin    [2];
  logic [N-1:0] cmd_data   [2];
  logic [N-1:0] alu_a      [2];
  logic [N-1:0] alu_b      [2];
  logic         alu_cin    [2];
  logic [M-1:0] alu_mode   [2];
  logic [N-1:0] alu_y      [2];
  logic         alu_cout   [2];
  logic         alu_overflow [2];
  logic         res_valid  [2];
  logic         res_ready  [2];
  logic [N-1:0] res_data   [2];
  logic         res_cout   [2];
  logic         res_ovf    [2];
  logic         ovf_sticky [2];
  logic         busy       [2];

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Behavioural ALU. Outside add/sub it drives junk flags (1) so masking is visible.
  function automatic alu_res_t alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic [M-1:0] mode, input logic cin);
    alu_res_t   r;
    logic [N:0] s;
    r.y = '0; r.cout = 1'b1; r.ovf = 1'b1;
    s = '0;
    case (mode)
      4'd0:  r.y = a & b;
      4'd1:  r.y = a | b;
      4'd2:  r.y = a ^ b;
      4'd3:  r.y = {a[N-1], a[N-1:1]};
      4'd4: begin
        s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        r.y = s[N-1:0]; r.cout = s[N];
        r.ovf = (a[N-1] == b[N-1]) && (r.y[N-1] != a[N-1]);
      end
      4'd5: begin
        s = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, cin};
        r.y = s[N-1:0]; r.cout = s[N];
        r.ovf = (a[N-1] != b[N-1]) && (r.y[N-1] != a[N-1]);
      end
      4'd15: r.y = a / 16'd3;
      default: r.y = b;
    endcase
    return r;
  endfunction

  alu_res_t dut_alu [2];
  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign dut_alu[g]      = alu_fn(alu_a[g], alu_b[g], alu_mode[g], alu_cin[g]);
    assign alu_y[g]        = dut_alu[g].y;
    assign alu_cout[g]     = dut_alu[g].cout;
    assign alu_overflow[g] = dut_alu[g].ovf;
  end

  alu_sequencer #(.N(N), .M(M), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_load(cmd_load[0]), .cmd_op(cmd_op[0]), .cmd_cin(cmd_cin[0]), .cmd_data(cmd_data[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_cin(alu_cin[0]), .alu_mode(alu_mode[0]),
    .alu_y(alu_y[0]), .alu_cout(alu_cout[0]), .alu_overflow(alu_overflow[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .res_cout(res_cout[0]), .res_ovf(res_ovf[0]), .ovf_sticky(ovf_sticky[0]), .busy(busy[0])
  );

  alu_sequencer #(.N(N), .M(M), .SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_load(cmd_load[1]), .cmd_op(cmd_op[1]), .cmd_cin(cmd_cin[1]), .cmd_data(cmd_data[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_cin(alu_cin[1]), .alu_mode(alu_mode[1]),
    .alu_y(alu_y[1]), .alu_cout(alu_cout[1]), .alu_overflow(alu_overflow[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .res_cout(res_cout[1]), .res_ovf(res_ovf[1]), .ovf_sticky(ovf_sticky[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: a command is either a pending result (m_resp) or an
  // operation with m_exec cycles of settle time left.
  logic [N-1:0] m_acc [2]  = '{default: '0};
  logic [N-1:0] m_b   [2]  = '{default: '0};
  logic [M-1:0] m_mode[2]  = '{default: '0};
  logic         m_cin [2]  = '{default: 1'b0};
  logic [N-1:0] m_rd  [2]  = '{default: '0};
  logic         m_rc  [2]  = '{default: 1'b0};
  logic         m_ro  [2]  = '{default: 1'b0};
  logic         m_stk [2]  = '{default: 1'b0};
  logic         m_resp[2]  = '{default: 1'b0};
  int           m_exec[2]  = '{default: 0};
  alu_res_t     m_alu [2];

  assign m_alu[0] = alu_fn(m_acc[0], m_b[0], m_mode[0], m_cin[0]);
  assign m_alu[1] = alu_fn(m_acc[1], m_b[1], m_mode[1], m_cin[1]);

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_acc[i] <= '0; m_b[i] <= '0; m_mode[i] <= '0; m_cin[i] <= 1'b0;
        m_rd[i] <= '0; m_rc[i] <= 1'b0; m_ro[i] <= 1'b0; m_stk[i] <= 1'b0;
        m_resp[i] <= 1'b0; m_exec[i] <= 0;
      end else if (m_exec[i] != 0) begin
        m_exec[i] <= m_exec[i] - 1;
        if (m_exec[i] == 1) begin
          m_acc[i]  <= m_alu[i].y;
          m_rd[i]   <= m_alu[i].y;
          m_rc[i]   <= (m_mode[i] == 4 || m_mode[i] == 5) ? m_alu[i].cout : 1'b0;
          m_ro[i]   <= (m_mode[i] == 4 || m_mode[i] == 5) ? m_alu[i].ovf  : 1'b0;
          m_stk[i]  <= m_stk[i] | ((m_mode[i] == 4 || m_mode[i] == 5) ? m_alu[i].ovf : 1'b0);
          m_resp[i] <= 1'b1;
        end
      end else if (m_resp[i]) begin
        if (res_ready[i]) m_resp[i] <= 1'b0;
      end else if (cmd_valid[i]) begin
        if (cmd_load[i]) begin
          m_acc[i] <= cmd_data[i]; m_rd[i] <= cmd_data[i];
          m_rc[i] <= 1'b0; m_ro[i] <= 1'b0; m_stk[i] <= 1'b0;
          m_resp[i] <= 1'b1;
        end else begin
          m_b[i] <= cmd_data[i]; m_mode[i] <= cmd_op[i]; m_cin[i] <= cmd_cin[i];
          m_exec[i] <= settle_of(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d_res_valid", i), res_valid[i], m_resp[i]);
        check($sformatf("u%0d_cmd_ready", i), cmd_ready[i], !m_resp[i] && m_exec[i] == 0);
        check($sformatf("u%0d_busy", i), busy[i], m_resp[i] || m_exec[i] != 0);
        check($sformatf("u%0d_alu_a", i), alu_a[i], m_acc[i]);
        check($sformatf("u%0d_alu_b", i), alu_b[i], m_b[i]);
        check($sformatf("u%0d_alu_mode", i), alu_mode[i], m_mode[i]);
        check($sformatf("u%0d_alu_cin", i), alu_cin[i], m_cin[i]);
        check($sformatf("u%0d_res_data", i), res_data[i], m_rd[i]);
        check($sformatf("u%0d_res_cout", i), res_cout[i], m_rc[i]);
        check($sformatf("u%0d_res_ovf", i), res_ovf[i], m_ro[i]);
        check($sformatf("u%0d_ovf_sticky", i), ovf_sticky[i], m_stk[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic load, input logic [M-1:0] op,
                      input logic cin, input logic [N-1:0] data);
    int n = 0;
    while (!cmd_ready[i] && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("u%0d_ready_before_send", i), cmd_ready[i], 1);
    cmd_valid[i] = 1'b1; cmd_load[i] = load; cmd_op[i] = op;
    cmd_cin[i] = cin; cmd_data[i] = data;
    tick();
    cmd_valid[i] = 1'b0;
  endtask

  // Called the cycle after acceptance; latency counts cycles from the accept edge.
  task automatic wait_result(input int i, output int lat);
    lat = 1;
    while (!res_valid[i] && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop(input int i);
    res_ready[i] = 1'b1;
    tick();
    res_ready[i] = 1'b0;
    check($sformatf("u%0d_pop_res_valid", i), res_valid[i], 0);
    check($sformatf("u%0d_pop_cmd_ready", i), cmd_ready[i], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_load[i] = 1'b0; cmd_op[i] = '0;
      cmd_cin[i] = 1'b0; cmd_data[i] = '0; res_ready[i] = 1'b0;
    end
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    cmp_en = 1'b1;

    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_rst_res_valid", i), res_valid[i], 0);
      check($sformatf("u%0d_rst_cmd_ready", i), cmd_ready[i], 1);
      check($sformatf("u%0d_rst_busy", i), busy[i], 0);
      check($sformatf("u%0d_rst_alu_a", i), alu_a[i], 0);
    end

    // SETTLE=1 instance
    send(0, 1'b1, 4'd0, 1'b0, 16'h7FFF);
    check("load_latency_valid", res_valid[0], 1);
    check("load_res_data", res_data[0], 16'h7FFF);
    check("load_res_cout", res_cout[0], 0);
    check("load_res_ovf", res_ovf[0], 0);
    check("load_alu_a", alu_a[0], 16'h7FFF);
    pop(0);

    send(0, 1'b0, 4'd4, 1'b0, 16'h0001);
    wait_result(0, lat);
    check("add_ovf_latency", lat, 2);
    check("add_ovf_res_data", res_data[0], 16'h8000);
    check("add_ovf_res_cout", res_cout[0], 0);
    check("add_ovf_res_ovf", res_ovf[0], 1);
    check("add_ovf_sticky", ovf_sticky[0], 1);
    pop(0);

    send(0, 1'b0, 4'd3, 1'b0, 16'h0000);
    wait_result(0, lat);
    check("asr_latency", lat, 2);
    check("asr_res_data", res_data[0], 16'hC000);
    check("asr_res_cout_masked", res_cout[0], 0);
    check("asr_res_ovf_masked", res_ovf[0], 0);
    check("asr_sticky_kept", ovf_sticky[0], 1);
    pop(0);

    send(0, 1'b1, 4'd0, 1'b0, 16'h0010);
    check("load2_sticky_cleared", ovf_sticky[0], 0);
    check("load2_res_data", res_data[0], 16'h0010);
    pop(0);

    send(0, 1'b0, 4'd15, 1'b0, 16'h0000);
    wait_result(0, lat);
    check("op15_res_data", res_data[0], 16'h0005);
    for (int k = 0; k < 5; k++) begin
      cmd_valid[0] = (k % 2 == 0); cmd_load[0] = 1'b1; cmd_data[0] = 16'hFFFF;
      tick();
      check("stall_res_valid", res_valid[0], 1);
      check("stall_res_data", res_data[0], 16'h0005);
      check("stall_cmd_ready", cmd_ready[0], 0);
      check("stall_acc", alu_a[0], 16'h0005);
    end
    cmd_valid[0] = 1'b0; cmd_load[0] = 1'b0;
    pop(0);
    check("after_stall_acc", alu_a[0], 16'h0005);

    send(0, 1'b0, 4'd5, 1'b1, 16'h0007);
    wait_result(0, lat);
    check("sub_res_data", res_data[0], 16'hFFFE);
    check("sub_res_cout", res_cout[0], 0);
    check("sub_res_ovf", res_ovf[0], 0);
    pop(0);

    send(0, 1'b0, 4'd4, 1'b1, 16'h0002);
    wait_result(0, lat);
    check("addc_res_data", res_data[0], 16'h0001);
    check("addc_res_cout", res_cout[0], 1);
    check("addc_res_ovf", res_ovf[0], 0);
    check("addc_sticky", ovf_sticky[0], 0);
    pop(0);

    // SETTLE=3 instance
    send(1, 1'b1, 4'd0, 1'b0, 16'h0001);
    pop(1);
    send(1, 1'b0, 4'd4, 1'b0, 16'h0002);
    for (int k = 0; k < 3; k++) begin
      check("s3_exec_busy", busy[1], 1);
      check("s3_exec_res_valid", res_valid[1], 0);
      check("s3_exec_alu_b", alu_b[1], 16'h0002);
      check("s3_exec_alu_mode", alu_mode[1], 4'd4);
      check("s3_exec_alu_a", alu_a[1], 16'h0001);
      tick();
    end
    check("s3_res_valid_at_accept_plus4", res_valid[1], 1);
    check("s3_res_data", res_data[1], 16'h0003);
    pop(1);

    send(1, 1'b0, 4'd4, 1'b0, 16'h0005);
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check("midexec_rst_res_valid", res_valid[1], 0);
    check("midexec_rst_cmd_ready", cmd_ready[1], 1);
    check("midexec_rst_acc", alu_a[1], 0);
    check("midexec_rst_alu_b", alu_b[1], 0);
    check("midexec_rst_busy", busy[1], 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (res_valid[1]) seen++;
    end
    check("midexec_rst_no_result", seen, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
